// File: rtl/video_capture_if.sv
`default_nettype none
// ============================================================================
//  Module    : video_if / wshb_if
//  Purpose   : Interfaces used by video_capture.
//              video_if : parallel RGB888 video with HS, VS and BLANK
//                         (BLANK=1 marks an active pixel, syncs are active low).
//              wshb_if  : 32-bit classic Wishbone write bus carrying its own
//                         clock and asynchronous active-high reset.
//  Ports     : wshb_if.clk, wshb_if.rst - bus clock and reset
//  Revision  : 1.0 - initial release
// ============================================================================
interface video_if;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;

    modport master (output rgb, hs, vs, blank);
    modport slave  (input  rgb, hs, vs, blank);
endinterface

interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (input  clk, rst, ack, dat_sm,
                    output adr, dat_ms, we, sel, cyc, stb, cti, bte);
    modport slave  (input  clk, rst, adr, dat_ms, we, sel, cyc, stb, cti, bte,
                    output ack, dat_sm);
endinterface
`default_nettype wire

// File: rtl/video_capture.sv
`default_nettype none
// ============================================================================
//  Module    : async_fifo
//  Purpose   : Dual-clock FIFO with Gray-coded pointers and show-ahead read
//              (rdata always presents the oldest word while not empty).
//  Ports     : wclk/wrst/wen/wdata/wfull - write side
//              rclk/rrst/ren/rdata/rempty - read side
//  Revision  : 1.0 - initial release
// ============================================================================
module async_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4          // must be >= 2
) (
    input  wire logic                  wclk,
    input  wire logic                  wrst,
    input  wire logic                  wen,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    output logic                       wfull,
    input  wire logic                  rclk,
    input  wire logic                  rrst,
    input  wire logic                  ren,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       rempty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] r_wbin, r_wgray, r_wq1_rgray, r_wq2_rgray;
    logic [ADDR_WIDTH:0] r_rbin, r_rgray, r_rq1_wgray, r_rq2_wgray;
    logic [ADDR_WIDTH:0] w_wbin_next, w_rbin_next;

    assign w_wbin_next = r_wbin + {{ADDR_WIDTH{1'b0}}, (wen & ~wfull)};
    assign w_rbin_next = r_rbin + {{ADDR_WIDTH{1'b0}}, (ren & ~rempty)};

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin      <= '0;
            r_wgray     <= '0;
            r_wq1_rgray <= '0;
            r_wq2_rgray <= '0;
        end else begin
            r_wbin      <= w_wbin_next;
            r_wgray     <= (w_wbin_next >> 1) ^ w_wbin_next;
            r_wq1_rgray <= r_rgray;
            r_wq2_rgray <= r_wq1_rgray;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen && !wfull)
            mem[r_wbin[ADDR_WIDTH-1:0]] <= wdata;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rbin      <= '0;
            r_rgray     <= '0;
            r_rq1_wgray <= '0;
            r_rq2_wgray <= '0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rgray     <= (w_rbin_next >> 1) ^ w_rbin_next;
            r_rq1_wgray <= r_wgray;
            r_rq2_wgray <= r_rq1_wgray;
        end
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign wfull  = (r_wgray == {~r_wq2_rgray[ADDR_WIDTH:ADDR_WIDTH-1],
                                  r_wq2_rgray[ADDR_WIDTH-2:0]});
    assign rempty = (r_rgray == r_rq2_wgray);
    assign rdata  = mem[r_rbin[ADDR_WIDTH-1:0]];
endmodule

// ============================================================================
//  Module    : video_capture
//  Purpose   : Captures active video frames into a linear framebuffer over a
//              Wishbone write master, crossing clock domains through a FIFO.
//  Ports     : pixel_clk, pixel_rst     - pixel clock / async active-high rst
//              video_ifs (slave)        - RGB, HS, VS, BLANK input
//              wshb_ifm (master)        - framebuffer write bus (own clk/rst)
//              capture_en, clr_status   - control (pixel domain)
//              frame_done, frame_cnt    - frame completion pulse / counter
//              overflow, line_err       - sticky drop / timing-error flags
//  Revision  : 1.0 - initial release
// ============================================================================
module video_capture #(
    parameter int          HDISP    = 800,
    parameter int          VDISP    = 480,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int          FIFO_AW  = 4
) (
    input  wire logic   pixel_clk,
    input  wire logic   pixel_rst,
    video_if.slave      video_ifs,
    wshb_if.master      wshb_ifm,
    input  wire logic   capture_en,
    input  wire logic   clr_status,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    output logic        line_err
);
    localparam int          XW       = $clog2(HDISP + 1);
    localparam int          YW       = $clog2(VDISP + 1);
    localparam logic [31:0] LAST_ADR = BASE_ADR + 32'(4 * HDISP * VDISP) - 32'd4;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_VS     = 2'd1,
        S_WAIT_ACTIVE = 2'd2,
        S_CAPTURE     = 2'd3
    } state_t;

    // ------------------------------------------------------------------ input
    logic [23:0] r_rgb;
    logic        r_hs, r_vs, r_vs_d, r_blank, r_blank_d;

    // Syncs idle high, so reset them high: no phantom VS edge after reset.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_rgb     <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_vs_d    <= 1'b1;
            r_blank   <= 1'b0;
            r_blank_d <= 1'b0;
        end else begin
            r_rgb     <= video_ifs.rgb;
            r_hs      <= video_ifs.hs;
            r_vs      <= video_ifs.vs;
            r_vs_d    <= r_vs;
            r_blank   <= video_ifs.blank;
            r_blank_d <= r_blank;
        end
    end

    logic w_vs_rise, w_vs_fall, w_blank_fall;
    assign w_vs_rise    =  r_vs & ~r_vs_d;
    assign w_vs_fall    = ~r_vs &  r_vs_d;
    assign w_blank_fall = ~r_blank & r_blank_d;

    // ------------------------------------------------------------------- FSM
    state_t        r_state, w_state_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_push, w_sof, w_start, w_line_end, w_frame_end, w_abort, w_hs_err;
    logic          w_wfull;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_sof        = 1'b0;
        w_start      = 1'b0;
        w_line_end   = 1'b0;
        w_frame_end  = 1'b0;
        w_abort      = 1'b0;
        w_hs_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (capture_en) w_state_next = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (w_vs_rise) w_state_next = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                if (r_blank) begin
                    w_push       = 1'b1;
                    w_sof        = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_push   = r_blank;
                // A horizontal sync during active video is a timing fault too.
                w_hs_err = r_blank & ~r_hs;
                if (w_blank_fall) begin
                    w_line_end = 1'b1;
                    if (r_y == YW'(VDISP - 1)) begin
                        w_frame_end  = 1'b1;
                        w_state_next = S_WAIT_VS;
                    end
                end
                if (w_vs_fall && !w_frame_end) begin
                    w_abort      = 1'b1;
                    w_state_next = S_WAIT_VS;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Disabling capture overrides everything: the frame is dropped silently.
        if (!capture_en) begin
            w_state_next = S_IDLE;
            w_push       = 1'b0;
            w_sof        = 1'b0;
            w_start      = 1'b0;
            w_line_end   = 1'b0;
            w_frame_end  = 1'b0;
            w_abort      = 1'b0;
            w_hs_err     = 1'b0;
        end
    end

    // --------------------------------------------------------------- counters
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_start) begin
            r_x <= XW'(1);
            r_y <= '0;
        end else if (!capture_en || w_frame_end || w_abort || r_state != S_CAPTURE) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_line_end) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
        end else if (w_push) begin
            r_x <= r_x + 1'b1;
        end
    end

    logic w_err_set, w_ovf_set;
    assign w_err_set = (w_line_end && (r_x != XW'(HDISP))) || w_abort || w_hs_err;
    // Dropped pixels still advance the counters, keeping frame geometry intact.
    assign w_ovf_set = w_push & w_wfull;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            frame_done <= w_frame_end;
            if (w_frame_end) frame_cnt <= frame_cnt + 16'd1;
            if (w_ovf_set)       overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
            if (w_err_set)       line_err <= 1'b1;
            else if (clr_status) line_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------- FIFO
    logic        w_fifo_rst, w_rempty, w_rd;
    logic [31:0] w_rdata;

    // Either reset flushes both pointer sets so they can never disagree.
    assign w_fifo_rst = pixel_rst | wshb_ifm.rst;

    async_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (FIFO_AW)
    ) u_fifo (
        .wclk   (pixel_clk),
        .wrst   (w_fifo_rst),
        .wen    (w_push & ~w_wfull),
        .wdata  ({7'b0, w_sof, r_rgb}),
        .wfull  (w_wfull),
        .rclk   (wshb_ifm.clk),
        .rrst   (w_fifo_rst),
        .ren    (w_rd),
        .rdata  (w_rdata),
        .rempty (w_rempty)
    );

    // -------------------------------------------------------------- wishbone
    logic [31:0] r_adr, w_cur_adr;
    logic        w_rd_sof;

    // The upper byte only ever carries the start-of-frame tag (0 or 1).
    assign w_rd_sof  = (w_rdata[31:24] == 8'h01);
    assign w_cur_adr = w_rd_sof ? BASE_ADR : r_adr;
    assign w_rd      = wshb_ifm.ack & ~w_rempty;

    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst)
            r_adr <= BASE_ADR;
        else if (w_rd)
            r_adr <= (w_cur_adr == LAST_ADR) ? BASE_ADR : w_cur_adr + 32'd4;
    end

    // Show-ahead FIFO output keeps adr/dat frozen until the word is acked.
    assign wshb_ifm.cyc    = ~w_rempty;
    assign wshb_ifm.stb    = ~w_rempty;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = w_cur_adr;
    assign wshb_ifm.dat_ms = {8'h00, w_rdata[23:0]};
endmodule
`default_nettype wire

// File: tb/tb_video_capture.sv
`default_nettype none
// ============================================================================
//  Module    : tb_video_capture
//  Purpose   : Self-checking bench for video_capture (HDISP=4, VDISP=2,
//              BASE_ADR=0x100). Stimulus pushes expected framebuffer writes
//              into a queue; a bus monitor pops and compares each write.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_video_capture;
    localparam int          HDISP = 4;
    localparam int          VDISP = 2;
    localparam logic [31:0] BASE  = 32'h100;

    logic        pclk = 1'b0;
    logic        wclk = 1'b0;
    logic        prst = 1'b1;
    logic        wrst = 1'b1;
    logic        capture_en = 1'b0;
    logic        clr_status = 1'b0;
    logic        ack_en = 1'b1;
    logic        frame_done, overflow, line_err;
    logic [15:0] frame_cnt;

    always #5 pclk = ~pclk;
    always #4 wclk = ~wclk;

    video_if vif();
    wshb_if  wif (.clk(wclk), .rst(wrst));

    assign wif.ack    = wif.stb & ack_en;
    assign wif.dat_sm = 32'h0;

    video_capture #(
        .HDISP    (HDISP),
        .VDISP    (VDISP),
        .BASE_ADR (BASE),
        .FIFO_AW  (2)
    ) dut (
        .pixel_clk  (pclk),
        .pixel_rst  (prst),
        .video_ifs  (vif),
        .wshb_ifm   (wif),
        .capture_en (capture_en),
        .clr_status (clr_status),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .line_err   (line_err)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  fd_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- monitors
    always @(negedge pclk) if (frame_done === 1'b1) fd_total++;

    logic        prev_wait = 1'b0;
    logic [31:0] prev_adr, prev_dat;

    always @(negedge wclk) begin
        if (!wrst) begin
            if (prev_wait && wif.stb) begin
                check("adr_stable", wif.adr, prev_adr);
                check("dat_stable", wif.dat_ms, prev_dat);
            end
            prev_wait = wif.stb & ~wif.ack;
            prev_adr  = wif.adr;
            prev_dat  = wif.dat_ms;
            if (wif.cyc && wif.stb && wif.ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got adr=%0h dat=%0h, expected no write",
                             wif.adr, wif.dat_ms);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wb_adr", wif.adr, e.adr);
                    check("wb_dat", wif.dat_ms, e.dat);
                    check("wb_ctl", {wif.cyc, wif.we, wif.sel, wif.cti, wif.bte},
                          {1'b1, 1'b1, 4'hF, 3'b000, 2'b00});
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    task automatic drive(input logic [23:0] rgb, input logic hs, input logic vs, input logic blank);
        @(posedge pclk);
        #1;
        vif.rgb   = rgb;
        vif.hs    = hs;
        vif.vs    = vs;
        vif.blank = blank;
    endtask

    task automatic vs_pulse();
        repeat (3) drive(24'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(24'h0, 1'b1, 1'b1, 1'b0);
    endtask

    // n active pixels valued v0.. ; if exp, expected writes start at index idx0
    task automatic line(input int n, input logic [23:0] v0, input bit exp, input int idx0);
        repeat (2) drive(24'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(24'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (exp) exp_q.push_back({BASE + 32'(4 * (idx0 + i)), 8'h00, v0 + 24'(i)});
            drive(v0 + 24'(i), 1'b1, 1'b1, 1'b1);
        end
        repeat (6) drive(24'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic frame(input logic [23:0] v0, input int n2);
        vs_pulse();
        line(HDISP, v0, 1'b1, 0);
        line(n2, v0 + 24'(HDISP), 1'b1, HDISP);
    endtask

    task automatic set_ack(input logic v);
        @(posedge wclk);
        #1 ack_en = v;
    endtask

    task automatic do_reset();
        prst       = 1'b1;
        wrst       = 1'b1;
        capture_en = 1'b0;
        clr_status = 1'b0;
        ack_en     = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        prst = 1'b0;
        wrst = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge wclk);
            t++;
        end
        repeat (40) @(posedge wclk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    int fd0;

    initial begin
        vif.rgb   = 24'h0;
        vif.hs    = 1'b1;
        vif.vs    = 1'b1;
        vif.blank = 1'b0;

        // reset state
        do_reset();
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_line_err", line_err, 1'b0);
        check("rst_stb", wif.stb, 1'b0);

        // one clean frame
        fd0 = fd_total;
        capture_en = 1'b1;
        repeat (3) drive(24'h0, 1'b1, 1'b1, 1'b0);
        frame(24'h000001, HDISP);
        wait_drain();
        check("clean_frame_done", 64'(fd_total - fd0), 64'd1);
        check("clean_frame_cnt", frame_cnt, 16'd1);
        check("clean_overflow", overflow, 1'b0);
        check("clean_line_err", line_err, 1'b0);

        // stalled bus: only the first line fits, the rest drops
        do_reset();
        capture_en = 1'b1;
        set_ack(1'b0);
        frame(24'h000010, 0);
        line(HDISP, 24'h000014, 1'b0, 0);
        repeat (150) @(posedge wclk);
        set_ack(1'b1);
        wait_drain();
        check("stall_overflow", overflow, 1'b1);
        check("stall_frame_cnt", frame_cnt, 16'd1);
        frame(24'h000020, HDISP);
        wait_drain();
        check("stall_next_cnt", frame_cnt, 16'd2);
        check("stall_sticky_ovf", overflow, 1'b1);

        // short second line
        do_reset();
        fd0 = fd_total;
        capture_en = 1'b1;
        frame(24'h000030, 3);
        wait_drain();
        check("short_line_err", line_err, 1'b1);
        check("short_frame_done", 64'(fd_total - fd0), 64'd1);
        check("short_frame_cnt", frame_cnt, 16'd1);
        @(posedge pclk);
        #1 clr_status = 1'b1;
        @(posedge pclk);
        #1 clr_status = 1'b0;
        @(negedge pclk);
        check("clr_line_err", line_err, 1'b0);

        // VS arrives after the first line
        do_reset();
        fd0 = fd_total;
        capture_en = 1'b1;
        vs_pulse();
        line(HDISP, 24'h000040, 1'b1, 0);
        vs_pulse();
        wait_drain();
        check("abort_line_err", line_err, 1'b1);
        check("abort_no_done", 64'(fd_total - fd0), 64'd0);
        check("abort_cnt", frame_cnt, 16'd0);
        frame(24'h000050, HDISP);
        wait_drain();
        check("abort_next_cnt", frame_cnt, 16'd1);

        // capture disabled mid-frame
        do_reset();
        fd0 = fd_total;
        capture_en = 1'b1;
        vs_pulse();
        line(HDISP, 24'h000060, 1'b1, 0);
        capture_en = 1'b0;
        line(HDISP, 24'h000064, 1'b0, 0);
        wait_drain();
        check("dis_no_done", 64'(fd_total - fd0), 64'd0);
        check("dis_cnt", frame_cnt, 16'd0);
        capture_en = 1'b1;
        frame(24'h000070, HDISP);
        wait_drain();
        check("dis_next_cnt", frame_cnt, 16'd1);
        check("dis_next_done", 64'(fd_total - fd0), 64'd1);

        // pixel reset mid-line
        do_reset();
        capture_en = 1'b1;
        frame(24'h000090, HDISP);
        wait_drain();
        check("prerst_cnt", frame_cnt, 16'd1);
        set_ack(1'b0);
        vs_pulse();
        repeat (2) drive(24'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(24'h0, 1'b1, 1'b1, 1'b0);
        drive(24'h0000A0, 1'b1, 1'b1, 1'b1);
        drive(24'h0000A1, 1'b1, 1'b1, 1'b1);
        #1 prst = 1'b1;
        #1;
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        check("midrst_frame_done", frame_done, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_line_err", line_err, 1'b0);
        drive(24'h0000A2, 1'b1, 1'b1, 1'b1);
        drive(24'h0000A3, 1'b1, 1'b1, 1'b1);
        #1 prst = 1'b0;
        set_ack(1'b1);
        repeat (6) drive(24'h0, 1'b1, 1'b1, 1'b0);
        line(HDISP, 24'h0000C0, 1'b0, 0);
        wait_drain();
        check("postrst_cnt", frame_cnt, 16'd0);
        frame(24'h0000B0, HDISP);
        wait_drain();
        check("postrst_next_cnt", frame_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
